// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: issue sequencer between decode and ALU_top.
// Handles operand select, ALU handshake, timeout, branch retire.
module alu_issue_ctrl #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int ERR_CNT_W      = 8
) (
  input  logic                 soc_clk,
  input  logic                 reset,
  input  logic                 issue_valid,
  output logic                 issue_ready,
  input  logic [5:0]           issue_op,
  input  logic [31:0]          issue_rs1_val,
  input  logic [31:0]          issue_rs2_val,
  input  logic [31:0]          issue_imm,
  input  logic                 issue_use_imm,
  input  logic [4:0]           issue_rd,
  input  logic [31:0]          issue_pc,
  output logic                 dat_ready,
  output logic [31:0]          ALU_dat1,
  output logic [31:0]          ALU_dat2,
  output logic [5:0]           Instruction_from_CU,
  input  logic [31:0]          ALU_out,
  input  logic                 ALU_zero,
  input  logic                 ALU_overflow,
  input  logic                 ALU_con_met,
  input  logic                 ALU_err,
  input  logic                 ALU_ready,
  output logic                 wb_valid,
  input  logic                 wb_ready,
  output logic                 wb_we,
  output logic [4:0]           wb_rd,
  output logic [31:0]          wb_data,
  output logic [2:0]           wb_flags,
  output logic                 br_taken,
  output logic [31:0]          br_target,
  output logic                 wb_err,
  output logic [ERR_CNT_W-1:0] err_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_PULSE,
    S_WAIT,
    S_RESP
  } state_t;

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t      state_q, state_d;
  logic [7:0]  tmo_q;
  logic [31:0] pc_q;
  logic [31:0] imm_q;
  logic [4:0]  rd_q;
  logic        is_br_q;

  logic in_br, in_alu, in_legal;
  logic accept, ret_alu, ret_tmo, wb_fire;

  assign in_br    = issue_op inside {[6'd4:6'd9]};
  assign in_alu   = issue_op inside {[6'd27:6'd36]};
  assign in_legal = in_br || in_alu;

  assign issue_ready = (state_q == S_IDLE);
  assign dat_ready   = (state_q == S_PULSE);
  assign wb_valid    = (state_q == S_RESP);

  assign accept  = issue_valid && issue_ready;
  assign ret_alu = (state_q == S_WAIT) && ALU_ready;
  assign ret_tmo = (state_q == S_WAIT) && !ALU_ready
                && (tmo_q == TMO_LAST);
  assign wb_fire = wb_valid && wb_ready;

  // State register
  always_ff @(posedge soc_clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:
        if (accept) state_d = in_legal ? S_SETUP : S_RESP;
      S_SETUP: state_d = S_PULSE;
      S_PULSE: state_d = S_WAIT;
      S_WAIT:
        if (ret_alu || ret_tmo) state_d = S_RESP;
      S_RESP:
        if (wb_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // WAIT-cycle counter, zeroed while the ALU is being pulsed
  always_ff @(posedge soc_clk or negedge reset) begin
    if (!reset)                 tmo_q <= '0;
    else if (state_q == S_WAIT) tmo_q <= tmo_q + 8'd1;
    else                        tmo_q <= '0;
  end

  // Captured operation fields
  always_ff @(posedge soc_clk or negedge reset) begin
    if (!reset) begin
      pc_q    <= '0;
      imm_q   <= '0;
      rd_q    <= '0;
      is_br_q <= 1'b0;
    end else if (accept) begin
      pc_q    <= issue_pc;
      imm_q   <= issue_imm;
      rd_q    <= issue_rd;
      is_br_q <= in_br;
    end
  end

  // ALU operand/opcode registers, live from SETUP to end of WAIT
  always_ff @(posedge soc_clk or negedge reset) begin
    if (!reset) begin
      ALU_dat1            <= '0;
      ALU_dat2            <= '0;
      Instruction_from_CU <= '0;
    end else if (accept && in_legal) begin
      ALU_dat1            <= issue_rs1_val;
      ALU_dat2            <= (in_alu && issue_use_imm)
                           ? issue_imm : issue_rs2_val;
      Instruction_from_CU <= issue_op;
    end else if (ret_alu || ret_tmo) begin
      ALU_dat1            <= '0;
      ALU_dat2            <= '0;
      Instruction_from_CU <= '0;
    end
  end

  // Retire bundle, loaded on entry to RESP and cleared on acceptance
  always_ff @(posedge soc_clk or negedge reset) begin
    if (!reset) begin
      wb_we     <= 1'b0;
      wb_rd     <= '0;
      wb_data   <= '0;
      wb_flags  <= '0;
      br_taken  <= 1'b0;
      br_target <= '0;
      wb_err    <= 1'b0;
    end else if (accept && !in_legal) begin
      wb_we     <= 1'b0;
      wb_rd     <= issue_rd;
      wb_data   <= '0;
      wb_flags  <= '0;
      br_taken  <= 1'b0;
      br_target <= '0;
      wb_err    <= 1'b1;
    end else if (ret_alu) begin
      wb_rd     <= rd_q;
      wb_flags  <= {ALU_overflow, ALU_zero, ALU_con_met};
      wb_err    <= ALU_err;
      if (is_br_q) begin
        wb_we     <= 1'b0;
        wb_data   <= '0;
        br_taken  <= ALU_con_met && !ALU_err;
        br_target <= pc_q + imm_q;
      end else begin
        wb_we     <= (rd_q != 5'd0) && !ALU_err;
        wb_data   <= ALU_out;
        br_taken  <= 1'b0;
        br_target <= '0;
      end
    end else if (ret_tmo) begin
      wb_we     <= 1'b0;
      wb_rd     <= rd_q;
      wb_data   <= '0;
      wb_flags  <= '0;
      br_taken  <= 1'b0;
      br_target <= is_br_q ? (pc_q + imm_q) : '0;
      wb_err    <= 1'b1;
    end else if (wb_fire) begin
      wb_we     <= 1'b0;
      wb_rd     <= '0;
      wb_data   <= '0;
      wb_flags  <= '0;
      br_taken  <= 1'b0;
      br_target <= '0;
      wb_err    <= 1'b0;
    end
  end

  // Saturating count of retired errors
  always_ff @(posedge soc_clk or negedge reset) begin
    if (!reset)
      err_count <= '0;
    else if (wb_fire && wb_err && !(&err_count))
      err_count <= err_count + 1'b1;
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl: directed checks of alu_issue_ctrl.
// ALU side is driven by hand from the stimulus tasks.
module tb_alu_issue_ctrl;

  localparam int T = 16;

  logic        soc_clk;
  logic        reset;
  logic        issue_valid;
  logic        issue_ready;
  logic [5:0]  issue_op;
  logic [31:0] issue_rs1_val;
  logic [31:0] issue_rs2_val;
  logic [31:0] issue_imm;
  logic        issue_use_imm;
  logic [4:0]  issue_rd;
  logic [31:0] issue_pc;
  logic        dat_ready;
  logic [31:0] ALU_dat1;
  logic [31:0] ALU_dat2;
  logic [5:0]  Instruction_from_CU;
  logic [31:0] ALU_out;
  logic        ALU_zero;
  logic        ALU_overflow;
  logic        ALU_con_met;
  logic        ALU_err;
  logic        ALU_ready;
  logic        wb_valid;
  logic        wb_ready;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic [2:0]  wb_flags;
  logic        br_taken;
  logic [31:0] br_target;
  logic        wb_err;
  logic [7:0]  err_count;

  int n_chk  = 0;
  int n_fail = 0;
  int pulses = 0;
  int p0;

  logic [31:0] a_res;
  logic        a_cm;
  logic        a_err;

  alu_issue_ctrl #(
    .TIMEOUT_CYCLES(T),
    .ERR_CNT_W(8)
  ) dut (
    .soc_clk(soc_clk),
    .reset(reset),
    .issue_valid(issue_valid),
    .issue_ready(issue_ready),
    .issue_op(issue_op),
    .issue_rs1_val(issue_rs1_val),
    .issue_rs2_val(issue_rs2_val),
    .issue_imm(issue_imm),
    .issue_use_imm(issue_use_imm),
    .issue_rd(issue_rd),
    .issue_pc(issue_pc),
    .dat_ready(dat_ready),
    .ALU_dat1(ALU_dat1),
    .ALU_dat2(ALU_dat2),
    .Instruction_from_CU(Instruction_from_CU),
    .ALU_out(ALU_out),
    .ALU_zero(ALU_zero),
    .ALU_overflow(ALU_overflow),
    .ALU_con_met(ALU_con_met),
    .ALU_err(ALU_err),
    .ALU_ready(ALU_ready),
    .wb_valid(wb_valid),
    .wb_ready(wb_ready),
    .wb_we(wb_we),
    .wb_rd(wb_rd),
    .wb_data(wb_data),
    .wb_flags(wb_flags),
    .br_taken(br_taken),
    .br_target(br_target),
    .wb_err(wb_err),
    .err_count(err_count)
  );

  initial soc_clk = 1'b0;
  always #5 soc_clk = ~soc_clk;

  // Count ALU start pulses seen at the clock edge
  always @(posedge soc_clk) if (dat_ready) pulses <= pulses + 1;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic start(input logic [5:0] op,
                       input logic [31:0] rs1,
                       input logic [31:0] rs2,
                       input logic [31:0] imm,
                       input logic ui,
                       input logic [4:0] rd,
                       input logic [31:0] pc);
    @(negedge soc_clk);
    p0            = pulses;
    issue_op      = op;
    issue_rs1_val = rs1;
    issue_rs2_val = rs2;
    issue_imm     = imm;
    issue_use_imm = ui;
    issue_rd      = rd;
    issue_pc      = pc;
    issue_valid   = 1'b1;
    @(negedge soc_clk);
    issue_valid   = 1'b0;
  endtask

  // From SETUP through PULSE into the first WAIT cycle
  task automatic to_wait(input string tag,
                         input logic [31:0] d1,
                         input logic [31:0] d2);
    chk({tag, "_setup_dr"}, 32'(dat_ready), 32'd0);
    @(negedge soc_clk);
    chk({tag, "_pulse_dr"}, 32'(dat_ready), 32'd1);
    chk({tag, "_dat1"}, ALU_dat1, d1);
    chk({tag, "_dat2"}, ALU_dat2, d2);
    @(negedge soc_clk);
  endtask

  // lat<0: ALU never answers; else answer after lat WAIT cycles
  task automatic respond(input int lat);
    if (lat < 0) begin
      repeat (T - 1) @(negedge soc_clk);
      chk("tmo_early", 32'(wb_valid), 32'd0);
      @(negedge soc_clk);
    end else begin
      repeat (lat) @(negedge soc_clk);
      ALU_out      = a_res;
      ALU_con_met  = a_cm;
      ALU_err      = a_err;
      ALU_zero     = (a_res == 32'd0);
      ALU_overflow = 1'b0;
      ALU_ready    = 1'b1;
      @(negedge soc_clk);
      ALU_ready    = 1'b0;
      ALU_out      = 32'hDEADBEEF;
      ALU_con_met  = 1'b0;
      ALU_err      = 1'b0;
      ALU_zero     = 1'b0;
    end
  endtask

  task automatic retire(input string tag);
    wb_ready = 1'b1;
    @(negedge soc_clk);
    wb_ready = 1'b0;
    chk({tag, "_drop"}, 32'(wb_valid), 32'd0);
    chk({tag, "_clr"}, wb_data | br_target, 32'd0);
  endtask

  int bad;
  int seen;
  logic [31:0] snap;

  initial begin
    reset         = 1'b0;
    issue_valid   = 1'b0;
    issue_op      = '0;
    issue_rs1_val = '0;
    issue_rs2_val = '0;
    issue_imm     = '0;
    issue_use_imm = 1'b0;
    issue_rd      = '0;
    issue_pc      = '0;
    ALU_out       = '0;
    ALU_zero      = 1'b0;
    ALU_overflow  = 1'b0;
    ALU_con_met   = 1'b0;
    ALU_err       = 1'b0;
    ALU_ready     = 1'b0;
    wb_ready      = 1'b0;
    a_res = '0; a_cm = 1'b0; a_err = 1'b0;

    repeat (3) @(negedge soc_clk);
    chk("rst_ir", 32'(issue_ready), 32'd1);
    chk("rst_wbv", 32'(wb_valid), 32'd0);
    chk("rst_dr", 32'(dat_ready), 32'd0);
    chk("rst_ec", 32'(err_count), 32'd0);
    reset = 1'b1;

    // ADD, ALU answers in first WAIT cycle
    a_res = 32'd15; a_cm = 1'b0; a_err = 1'b0;
    start(6'd27, 32'd10, 32'd5, 32'd99, 1'b0, 5'd3, 32'h0);
    to_wait("add", 32'd10, 32'd5);
    chk("add_op", 32'(Instruction_from_CU), 32'd27);
    respond(0);
    chk("add_wbv", 32'(wb_valid), 32'd1);
    chk("add_ir", 32'(issue_ready), 32'd0);
    chk("add_we", 32'(wb_we), 32'd1);
    chk("add_rd", 32'(wb_rd), 32'd3);
    chk("add_data", wb_data, 32'd15);
    chk("add_err", 32'(wb_err), 32'd0);
    chk("add_br", 32'(br_taken), 32'd0);
    chk("add_pulses", 32'(pulses - p0), 32'd1);
    retire("add");
    chk("add_ir_back", 32'(issue_ready), 32'd1);

    // SUB with immediate, rd=0
    a_res = 32'hFFFFFFFB;
    start(6'd28, 32'd5, 32'd7, 32'd10, 1'b1, 5'd0, 32'h0);
    to_wait("sub", 32'd5, 32'd10);
    respond(2);
    chk("sub_data", wb_data, 32'hFFFFFFFB);
    chk("sub_we", 32'(wb_we), 32'd0);
    retire("sub");

    // BEQ ignores use_imm
    a_res = 32'd0; a_cm = 1'b0;
    start(6'd4, 32'd5, 32'd7, 32'd10, 1'b1, 5'd0, 32'h40);
    to_wait("beq", 32'd5, 32'd7);
    respond(0);
    chk("beq_data", wb_data, 32'd0);
    chk("beq_tgt", br_target, 32'h4A);
    retire("beq");

    // BLT taken and not taken
    for (int k = 0; k < 2; k++) begin
      a_res = 32'd1; a_cm = (k == 0);
      start(6'd6, 32'hFFFFFFFB, 32'd5, 32'hFFFFFFF0,
            1'b0, 5'd9, 32'h100);
      to_wait("blt", 32'hFFFFFFFB, 32'd5);
      respond(1);
      chk("blt_taken", 32'(br_taken), 32'(k == 0));
      chk("blt_tgt", br_target, 32'hF0);
      chk("blt_we", 32'(wb_we), 32'd0);
      chk("blt_flags", 32'(wb_flags), (k == 0) ? 32'd1 : 32'd0);
      retire("blt");
    end

    // Illegal opcode
    start(6'd63, 32'd1, 32'd2, 32'd3, 1'b0, 5'd4, 32'h0);
    chk("ill_wbv", 32'(wb_valid), 32'd1);
    chk("ill_err", 32'(wb_err), 32'd1);
    chk("ill_we", 32'(wb_we), 32'd0);
    chk("ill_pulses", 32'(pulses - p0), 32'd0);
    retire("ill");
    chk("ill_ec", 32'(err_count), 32'd1);

    // ALU_err on an ALU op
    a_res = 32'd77; a_cm = 1'b0; a_err = 1'b1;
    start(6'd30, 32'd1, 32'd2, 32'd0, 1'b0, 5'd5, 32'h0);
    to_wait("aerr", 32'd1, 32'd2);
    respond(0);
    chk("aerr_err", 32'(wb_err), 32'd1);
    chk("aerr_we", 32'(wb_we), 32'd0);
    retire("aerr");
    chk("aerr_ec", 32'(err_count), 32'd2);
    a_err = 1'b0;

    // Timeout: ALU never answers
    start(6'd29, 32'd3, 32'd4, 32'd0, 1'b0, 5'd6, 32'h0);
    to_wait("tmo", 32'd3, 32'd4);
    respond(-1);
    chk("tmo_wbv", 32'(wb_valid), 32'd1);
    chk("tmo_err", 32'(wb_err), 32'd1);
    chk("tmo_we", 32'(wb_we), 32'd0);
    retire("tmo");
    chk("tmo_ec", 32'(err_count), 32'd3);

    // ALU_ready on the final WAIT cycle wins
    a_res = 32'h1234;
    start(6'd29, 32'd3, 32'd4, 32'd0, 1'b0, 5'd6, 32'h0);
    to_wait("tlast", 32'd3, 32'd4);
    respond(T - 1);
    chk("tlast_err", 32'(wb_err), 32'd0);
    chk("tlast_we", 32'(wb_we), 32'd1);
    chk("tlast_data", wb_data, 32'h1234);
    retire("tlast");

    // Backpressure for 10 cycles
    a_res = 32'd3;
    start(6'd27, 32'd1, 32'd2, 32'd0, 1'b0, 5'd7, 32'h0);
    to_wait("bp", 32'd1, 32'd2);
    respond(2);
    snap = wb_data;
    bad  = 0;
    repeat (10) begin
      @(negedge soc_clk);
      if (!wb_valid || issue_ready || wb_data !== snap
          || wb_rd !== 5'd7 || !wb_we) bad++;
    end
    chk("bp_data", snap, 32'd3);
    chk("bp_stable", 32'(bad), 32'd0);
    retire("bp");

    // Reset while in WAIT
    start(6'd27, 32'd8, 32'd9, 32'd0, 1'b0, 5'd2, 32'h0);
    to_wait("rw", 32'd8, 32'd9);
    @(negedge soc_clk);
    #2 reset = 1'b0;
    #1;
    chk("rw_ir", 32'(issue_ready), 32'd1);
    chk("rw_dat1", ALU_dat1, 32'd0);
    chk("rw_ec", 32'(err_count), 32'd0);
    chk("rw_wbv", 32'(wb_valid), 32'd0);
    @(negedge soc_clk);
    reset = 1'b1;
    seen = 0;
    repeat (T + 4) begin
      @(negedge soc_clk);
      if (wb_valid) seen++;
    end
    chk("rw_noret", 32'(seen), 32'd0);

    // Reset during PULSE drops dat_ready at once
    start(6'd27, 32'd8, 32'd9, 32'd0, 1'b0, 5'd2, 32'h0);
    @(negedge soc_clk);
    chk("rp_pulse", 32'(dat_ready), 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("rp_dr", 32'(dat_ready), 32'd0);
    chk("rp_ir", 32'(issue_ready), 32'd1);
    @(negedge soc_clk);
    reset = 1'b1;
    repeat (2) @(negedge soc_clk);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
